// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register for pc / instruction / immediate.
// The stage uses a valid/ready handshake on both sides.
// Control priority on each edge is flush, then stall, then normal flow.
// kill_cnt counts the valid entries that a flush destroys and saturates at
// its maximum value.
// Optional feature: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
// With the skid entry, in_ready comes from a flop and has no combinational
// path from out_ready.
module pipe_stage_reg #(
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int IMM_W      = 32,
  parameter int CNT_W      = 8,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [IMM_W-1:0]   in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [IMM_W-1:0]   out_imm,
  output logic [CNT_W-1:0]   kill_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [IMM_W-1:0]   imm;
  } entry_t;

  entry_t             in_ent;
  entry_t             main_q, main_d;
  logic               main_valid_q, main_valid_d;
  logic [CNT_W-1:0]   kill_cnt_q, kill_cnt_d;
  logic [1:0]         held;
  logic [CNT_W:0]     kill_sum;
  logic               in_fire, out_fire;

  assign in_ent    = '{pc: in_pc, instr: in_instr, imm: in_imm};
  assign out_valid = main_valid_q & ~stall & ~flush;
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign out_imm   = main_q.imm;
  assign kill_cnt  = kill_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  // in_ready depends only on the skid flop and the control inputs.
  // When main is full and blocked, the skid entry absorbs one in-flight beat.
  assign in_ready = ~skid_valid_q & ~stall & ~flush;
  assign held     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  // Single entry: accept when empty or when the held entry drains this cycle.
  assign in_ready = ~stall & ~flush & (~main_valid_q | out_ready);
  assign held     = {1'b0, main_valid_q};
`endif

  // Saturating sum of the current kill count and the entries a flush destroys.
  assign kill_sum = {1'b0, kill_cnt_q} + (CNT_W+1)'(held);

  // Next-state selection: flush beats stall, and stall beats normal flow.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    kill_cnt_d   = kill_cnt_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      kill_cnt_d   = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
      if (FLUSH_ZERO) main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
      if (FLUSH_ZERO) skid_d = '0;
`endif
    end else if (!stall) begin
`ifdef PIPE_STAGE_SKID_EN
      if (out_fire) begin
        if (skid_valid_q) begin
          // Refill main from skid. in_ready is low, so no new beat arrives.
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d = in_ent;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (main_valid_q) begin
          skid_d       = in_ent;
          skid_valid_d = 1'b1;
        end else begin
          main_d       = in_ent;
          main_valid_d = 1'b1;
        end
      end
`else
      if (in_fire) begin
        main_d       = in_ent;
        main_valid_d = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
`endif
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      kill_cnt_q   <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      kill_cnt_q   <= kill_cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`endif

endmodule
